// File: rtl/disparity_sad_engine_if.sv
// disparity_sad_engine_if: pixel-in stream, disparity-out stream and control of the SAD engine.
interface disparity_sad_engine_if #(
  parameter int PIX_W = 8,
  parameter int DISP_W = 4
);
  logic start, pix_valid, pix_ready, image_sel, disp_valid, disp_ready, disp_href, disp_vref, idle;
  logic [PIX_W-1:0] pix_in;
  logic [DISP_W-1:0] disp_out;
  modport master (
    output start, pix_in, pix_valid, disp_ready,
    input pix_ready, image_sel, disp_out, disp_valid, disp_href, disp_vref, idle
  );
  modport slave (
    input start, pix_in, pix_valid, disp_ready,
    output pix_ready, image_sel, disp_out, disp_valid, disp_href, disp_vref, idle
  );
endinterface

// File: rtl/disparity_sad_engine.sv
// disparity_sad_engine: stereo block matcher, streams min-SAD disparity per left pixel in raster order.
// Optional DISP_SAD_THRESH_EN: disp_out forced to 0 when the best SAD exceeds SAD_THRESH.
module disparity_sad_engine #(
  parameter int WIDTH = 46,
  parameter int HEIGHT = 30,
  parameter int HALF_BLOCK = 3,
  parameter int MAX_DISP = 15,
  parameter int PIX_W = 8,
  parameter int SAD_THRESH = 1024
) (
  input logic clk,
  input logic reset,
  disparity_sad_engine_if.slave bus
);
  localparam int DISP_W = $clog2(MAX_DISP + 1);
  localparam int SAD_W = PIX_W + $clog2((2 * HALF_BLOCK + 1) ** 2);
  localparam int N = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(WIDTH + HEIGHT + 2 * HALF_BLOCK + MAX_DISP + 2);
  localparam logic [CW-1:0] HB = CW'(HALF_BLOCK);
  localparam logic [CW-1:0] XM = CW'(WIDTH - 1);
  localparam logic [CW-1:0] YM = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] DM = CW'(MAX_DISP);
  localparam logic [AW-1:0] WD = AW'(WIDTH);
  localparam logic [AW-1:0] NM = AW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD_L, LOAD_R, SEARCH, EMIT} state_t;
  typedef enum logic [1:0] {ISSUE, DRAIN, CMP} phase_t;

  function automatic logic [CW-1:0] lo(input logic [CW-1:0] v);
    return v >= HB ? v - HB : '0;
  endfunction

  function automatic logic [CW-1:0] hi(input logic [CW-1:0] v, input logic [CW-1:0] m);
    return v + HB > m ? m : v + HB;
  endfunction

  function automatic logic [AW-1:0] addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * WD + AW'(c);
  endfunction

  state_t st;
  phase_t ph;
  logic [PIX_W-1:0] lram [N];
  logic [PIX_W-1:0] rram [N];
  logic [PIX_W-1:0] lq, rq, ad;
  logic [AW-1:0] wa;
  logic [CW-1:0] px, py, d, wr, wc, r0, r1, c0, c1, dmax, nx, ny;
  logic rd_v, better, last_px;
  logic [SAD_W-1:0] acc, best, nb;
  logic [DISP_W-1:0] best_d, nbd, disp_out;
  logic pix_ready, image_sel, disp_valid, href, vref, idle;

  assign bus.pix_ready = pix_ready;
  assign bus.image_sel = image_sel;
  assign bus.disp_out = disp_out;
  assign bus.disp_valid = disp_valid;
  assign bus.disp_href = href;
  assign bus.disp_vref = vref;
  assign bus.idle = idle;

  always_comb begin
    r0 = lo(py);
    r1 = hi(py, YM);
    c0 = lo(px);
    c1 = hi(px, XM);
    dmax = XM - c1 > DM ? DM : XM - c1;
    ad = lq > rq ? lq - rq : rq - lq;
    better = d == '0 || acc < best;
    nb = better ? acc : best;
    nbd = better ? DISP_W'(d) : best_d;
    last_px = px == XM && py == YM;
    nx = px == XM ? '0 : px + CW'(1);
    ny = px == XM ? py + CW'(1) : py;
  end

  // Frame RAMs: written during load, read with one cycle latency during search.
  always_ff @(posedge clk) begin
    if (reset && pix_ready && bus.pix_valid) begin
      if (image_sel) rram[wa] <= bus.pix_in;
      else lram[wa] <= bus.pix_in;
    end
    lq <= lram[addr(wr, wc)];
    rq <= rram[addr(wr, wc + d)];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      ph <= ISSUE;
      wa <= '0;
      px <= '0;
      py <= '0;
      d <= '0;
      wr <= '0;
      wc <= '0;
      rd_v <= 1'b0;
      acc <= '0;
      best <= '0;
      best_d <= '0;
      pix_ready <= 1'b0;
      image_sel <= 1'b0;
      disp_out <= '0;
      disp_valid <= 1'b0;
      href <= 1'b0;
      vref <= 1'b0;
      idle <= 1'b1;
    end else begin
      if (rd_v) acc <= acc + SAD_W'(ad);
      case (st)
        IDLE: if (bus.start) begin
          st <= LOAD_L;
          pix_ready <= 1'b1;
          image_sel <= 1'b0;
          idle <= 1'b0;
          wa <= '0;
        end
        LOAD_L, LOAD_R: if (bus.pix_valid) begin
          wa <= wa == NM ? '0 : wa + AW'(1);
          if (wa == NM) begin
            image_sel <= st == LOAD_L;
            if (st == LOAD_L) st <= LOAD_R;
            else begin
              st <= SEARCH;
              pix_ready <= 1'b0;
              ph <= ISSUE;
              px <= '0;
              py <= '0;
              d <= '0;
              wr <= '0;
              wc <= '0;
              acc <= '0;
            end
          end
        end
        SEARCH: case (ph)
          ISSUE: begin
            rd_v <= 1'b1;
            if (wc != c1) wc <= wc + CW'(1);
            else if (wr != r1) begin
              wc <= c0;
              wr <= wr + CW'(1);
            end else ph <= DRAIN;
          end
          DRAIN: begin
            rd_v <= 1'b0;
            ph <= CMP;
          end
          default: begin
            best <= nb;
            best_d <= nbd;
            acc <= '0;
            wr <= r0;
            wc <= c0;
            ph <= ISSUE;
            if (d == dmax) begin
              st <= EMIT;
              disp_valid <= 1'b1;
              href <= px == XM;
              vref <= last_px;
`ifdef DISP_SAD_THRESH_EN
              disp_out <= 32'(nb) > SAD_THRESH ? '0 : nbd;
`else
              disp_out <= nbd;
`endif
            end else d <= d + CW'(1);
          end
        endcase
        EMIT: if (bus.disp_ready) begin
          disp_valid <= 1'b0;
          href <= 1'b0;
          vref <= 1'b0;
          d <= '0;
          if (last_px) begin
            st <= IDLE;
            idle <= 1'b1;
          end else begin
            st <= SEARCH;
            px <= nx;
            py <= ny;
            wr <= lo(ny);
            wc <= lo(nx);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
